// File: rtl/sdram_cmd_scheduler.sv
// SDRAM command scheduler: arbitrates read/write/refresh and sequences
// ACTIVE, READ/WRITE-with-autoprecharge, PRECHARGE and AUTO-REFRESH strobes.
module sdram_cmd_scheduler #(
  parameter int unsigned REF_INTERVAL = 390,
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_RP         = 2,
  parameter int unsigned T_RFC        = 7
) (
  input  logic       clk0,
  input  logic       reset_n,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       page_mod,
  input  logic       page_stop,
  input  logic [3:0] bur_len,
  input  logic [1:0] cas_lat,
  output logic       do_active,
  output logic       do_reada,
  output logic       do_writea1,
  output logic       do_preacharge,
  output logic       do_refresh,
  output logic       rd_ack,
  output logic       wr_ack,
  output logic       busy,
  output logic       ref_pending
);

  localparam int unsigned CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int unsigned TMR_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REF_INTERVAL - 1);
  localparam logic [TMR_W-1:0] RCD_LOAD = (T_RCD > 1) ? TMR_W'(T_RCD - 2) : '0;
  localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] RFC_LOAD = (T_RFC > 1) ? TMR_W'(T_RFC - 2) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD, S_CMD, S_DATA, S_PRE, S_RP, S_REF, S_RFC
  } state_t;

  state_t             state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [CNT_W-1:0]   ref_cnt;
  logic               expire;
  logic               ref_nx;
  logic               rr_wr_next, rr_nx;
  logic               lat_wr, lat_wr_nx;
  logic               lat_page, lat_page_nx;
  logic [TMR_W-1:0]   lat_bl, lat_bl_nx;
  logic [1:0]         lat_cl, lat_cl_nx;
  logic [TMR_W-1:0]   bl_dec;
  logic               grant_wr;

  assign expire = (ref_cnt == '0);

  // Free-running refresh interval counter
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) ref_cnt <= CNT_LOAD;
    else if (expire) ref_cnt <= CNT_LOAD;
    else ref_cnt <= ref_cnt - CNT_W'(1);
  end

  // Next-state, timer and latched-access logic
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    rr_nx       = rr_wr_next;
    lat_wr_nx   = lat_wr;
    lat_page_nx = lat_page;
    lat_bl_nx   = lat_bl;
    lat_cl_nx   = lat_cl;
    ref_nx      = ref_pending | expire;
    grant_wr    = 1'b0;
    bl_dec      = 4'd1;
    case (bur_len)
      4'd1, 4'd2, 4'd4, 4'd8: bl_dec = bur_len;
      default:                bl_dec = 4'd1;
    endcase
    case (state)
      S_IDLE: begin
        if (ref_pending) begin
          state_nx = S_REF;
          ref_nx   = expire;
        end else if (rd_req || wr_req) begin
          grant_wr    = wr_req && (!rd_req || rr_wr_next);
          state_nx    = S_ACT;
          lat_wr_nx   = grant_wr;
          rr_nx       = !grant_wr;
          lat_page_nx = page_mod;
          lat_bl_nx   = bl_dec;
          lat_cl_nx   = (cas_lat == 2'd2) ? 2'd2 : 2'd3;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_nx = S_RCD;
          timer_nx = RCD_LOAD;
        end else begin
          state_nx = S_CMD;
        end
      end
      S_RCD: begin
        if (timer == '0) state_nx = S_CMD;
        else timer_nx = timer - TMR_W'(1);
      end
      S_CMD: begin
        state_nx = S_DATA;
        timer_nx = lat_wr ? (lat_bl - TMR_W'(1))
                          : (lat_bl + TMR_W'(lat_cl) - TMR_W'(1));
      end
      S_DATA: begin
        if (lat_page) begin
          if (page_stop) state_nx = S_PRE;
        end else if (timer == '0) begin
          state_nx = S_RP;
          timer_nx = RP_LOAD;
        end else begin
          timer_nx = timer - TMR_W'(1);
        end
      end
      S_PRE: begin
        state_nx = S_RP;
        timer_nx = RP_LOAD;
      end
      S_RP: begin
        if (timer == '0) state_nx = S_IDLE;
        else timer_nx = timer - TMR_W'(1);
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_nx = S_RFC;
          timer_nx = RFC_LOAD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RFC: begin
        if (timer == '0) state_nx = S_IDLE;
        else timer_nx = timer - TMR_W'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, latched access fields and registered strobes
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      rr_wr_next    <= 1'b1;
      lat_wr        <= 1'b0;
      lat_page      <= 1'b0;
      lat_bl        <= 4'd1;
      lat_cl        <= 2'd3;
      ref_pending   <= 1'b0;
      do_active     <= 1'b0;
      do_reada      <= 1'b0;
      do_writea1    <= 1'b0;
      do_preacharge <= 1'b0;
      do_refresh    <= 1'b0;
      rd_ack        <= 1'b0;
      wr_ack        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      rr_wr_next    <= rr_nx;
      lat_wr        <= lat_wr_nx;
      lat_page      <= lat_page_nx;
      lat_bl        <= lat_bl_nx;
      lat_cl        <= lat_cl_nx;
      ref_pending   <= ref_nx;
      do_active     <= (state_nx == S_ACT);
      do_reada      <= (state_nx == S_CMD) && !lat_wr_nx;
      do_writea1    <= (state_nx == S_CMD) && lat_wr_nx;
      do_preacharge <= (state_nx == S_PRE);
      do_refresh    <= (state_nx == S_REF);
      rd_ack        <= (state_nx == S_ACT) && !lat_wr_nx;
      wr_ack        <= (state_nx == S_ACT) && lat_wr_nx;
      busy          <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Bench for sdram_cmd_scheduler: predicts strobe cycles from the access
// timing rules and compares them cycle by cycle.
module tb_sdram_cmd_scheduler;

  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  localparam int T_RFC = 7;
  localparam int R_INT = 20;
  localparam int R_RCD = 1;

  logic       clk0 = 1'b0;
  logic       reset_n = 1'b1;
  logic       rd_req = 1'b0, wr_req = 1'b0, page_mod = 1'b0, page_stop = 1'b0;
  logic [3:0] bur_len = 4'd1;
  logic [1:0] cas_lat = 2'd2;

  logic d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy, d_pend;
  logic r_act, r_rda, r_wra, r_pre, r_ref, r_rack, r_wack, r_busy, r_pend;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  sdram_cmd_scheduler dut (
    .clk0(clk0), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
    .page_mod(page_mod), .page_stop(page_stop), .bur_len(bur_len), .cas_lat(cas_lat),
    .do_active(d_act), .do_reada(d_rda), .do_writea1(d_wra), .do_preacharge(d_pre),
    .do_refresh(d_ref), .rd_ack(d_rack), .wr_ack(d_wack), .busy(d_busy),
    .ref_pending(d_pend)
  );

  sdram_cmd_scheduler #(.REF_INTERVAL(R_INT), .T_RCD(R_RCD)) dut_r (
    .clk0(clk0), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
    .page_mod(page_mod), .page_stop(page_stop), .bur_len(bur_len), .cas_lat(cas_lat),
    .do_active(r_act), .do_reada(r_rda), .do_writea1(r_wra), .do_preacharge(r_pre),
    .do_refresh(r_ref), .rd_ack(r_rack), .wr_ack(r_wack), .busy(r_busy),
    .ref_pending(r_pend)
  );

  task automatic do_reset(output int r0);
    @(negedge clk0);
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; page_mod = 1'b0;
    page_stop = 1'b0; bur_len = 4'd1; cas_lat = 2'd2;
    repeat (3) @(negedge clk0);
    reset_n = 1'b1;
    r0 = cyc;
  endtask

  task automatic test_reset;
    int r0;
    @(negedge clk0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk0);
    checks++;
    if ({d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy, d_pend} !== 9'b0) begin
      errors++;
      $display("FAIL reset_main got=%b exp=000000000",
               {d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy, d_pend});
    end
    checks++;
    if ({r_act, r_rda, r_wra, r_pre, r_ref, r_rack, r_wack, r_busy, r_pend} !== 9'b0) begin
      errors++;
      $display("FAIL reset_refdut got=%b exp=000000000",
               {r_act, r_rda, r_wra, r_pre, r_ref, r_rack, r_wack, r_busy, r_pend});
    end
    do_reset(r0);
  endtask

  // Directed table entries first, then randomized single accesses
  task automatic test_access;
    bit  tw[6]  = '{1, 0, 1, 0, 0, 0};
    int  tbl[6] = '{4, 8, 4, 5, 1, 2};
    int  tcl[6] = '{2, 3, 2, 0, 2, 1};
    bit  tpg[6] = '{0, 0, 1, 0, 0, 1};
    int  tso[6] = '{1, 1, 20, 1, 1, 1};
    bit  wr, pg;
    logic [3:0] bl;
    logic [1:0] cl;
    int  so, r0, a, s, idle, ebl, ecl, len;
    logic [7:0] got, exp;
    for (int i = 0; i < 22; i++) begin
      if (i < 6) begin
        wr = tw[i]; bl = 4'(tbl[i]); cl = 2'(tcl[i]); pg = tpg[i]; so = tso[i];
      end else begin
        wr = 1'($urandom_range(0, 1));
        bl = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3))
                                         : 4'($urandom_range(0, 15));
        cl = 2'($urandom_range(0, 3));
        pg = ($urandom_range(0, 2) == 0);
        so = $urandom_range(1, 25);
      end
      ebl  = (bl == 4'd1 || bl == 4'd2 || bl == 4'd4 || bl == 4'd8) ? int'(bl) : 1;
      ecl  = (cl == 2'd2) ? 2 : 3;
      len  = wr ? ebl : ebl + ecl;
      do_reset(r0);
      wr_req = wr; rd_req = !wr; bur_len = bl; cas_lat = cl; page_mod = pg;
      a    = r0 + 1;
      s    = a + T_RCD + so;
      idle = pg ? s + 2 + T_RP : a + T_RCD + 1 + len + T_RP;
      for (int c = a; c <= idle + 2; c++) begin
        @(negedge clk0);
        exp = {cyc == a, (cyc == a + T_RCD) && !wr, (cyc == a + T_RCD) && wr,
               pg && (cyc == s + 1), 1'b0, (cyc == a) && !wr, (cyc == a) && wr,
               (cyc >= a) && (cyc < idle)};
        got = {d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL access[%0d] wr=%0d bl=%0d cl=%0d pg=%0d cycle+%0d got=%b exp=%b",
                   i, wr, bl, cl, pg, cyc - a, got, exp);
        end
        if (cyc == a) begin
          rd_req = 1'b0; wr_req = 1'b0;
          bur_len = 4'($urandom); cas_lat = 2'($urandom); page_mod = !pg;
        end
        // A pulse during CMD must be ignored; only DATA samples page_stop
        page_stop = pg ? ((cyc == s) || (cyc == a + T_RCD)) : 1'($urandom_range(0, 1));
      end
      page_stop = 1'b0;
    end
  endtask

  task automatic test_round_robin;
    int  r0, n;
    bit  exp_wr, seen;
    do_reset(r0);
    bur_len = 4'd1; cas_lat = 2'd2; rd_req = 1'b1; wr_req = 1'b1;
    n = 0; exp_wr = 1'b1;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk0);
      if (d_rack || d_wack) begin
        checks++;
        if ({d_wack, d_rack} !== {exp_wr, !exp_wr}) begin
          errors++;
          $display("FAIL rr_alternate grant%0d got wr/rd=%b%b exp=%b%b",
                   n, d_wack, d_rack, exp_wr, !exp_wr);
        end
        exp_wr = !exp_wr;
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rr_timeout grants=%0d exp=4", n);
    end
    do_reset(r0);
    bur_len = 4'd1; wr_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk0);
      seen = d_wack;
    end
    rd_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk0);
      seen = d_rack || d_wack;
    end
    checks++;
    if ({seen, d_rack, d_wack} !== 3'b110) begin
      errors++;
      $display("FAIL rr_after_write got seen/rd/wr=%b%b%b exp=110", seen, d_rack, d_wack);
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_refresh_priority;
    int r0, k;
    logic [4:0] got, exp;
    do_reset(r0);
    bur_len = 4'd1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk0);
      k = cyc - r0;
      exp = {k == R_INT + 1, k == R_INT + T_RFC + 2, k == R_INT + T_RFC + 2, k == R_INT,
             ((k >= R_INT + 1) && (k < R_INT + T_RFC + 1)) || (k >= R_INT + T_RFC + 2)};
      got = {r_ref, r_act, r_wack, r_pend, r_busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ref_priority cycle %0d got=%b exp=%b", k, got, exp);
      end
      if (k == R_INT) wr_req = 1'b1;
      if (r_wack) wr_req = 1'b0;
    end
    wr_req = 1'b0;
  endtask

  // Expiries during a long page access collapse into one refresh
  task automatic test_ref_no_queue;
    int r0, k, stop, r1, r2;
    logic pend;
    logic [4:0] got, exp;
    for (int v = 0; v < 2; v++) begin
      stop = (v == 0) ? 50 : 55;
      r1   = stop + 1 + T_RP + 2;
      r2   = r1 + T_RFC + 1;
      do_reset(r0);
      wr_req = 1'b1; page_mod = 1'b1; bur_len = 4'd4;
      for (int c = 1; c <= 70; c++) begin
        @(negedge clk0);
        k = cyc - r0;
        pend = ((k >= R_INT) && (k < r1)) || ((k >= 3 * R_INT) && (k < r2));
        exp = {k == 1, k == 1 + R_RCD, k == stop + 1, (k == r1) || (k == r2), pend};
        got = {r_act, r_wra, r_pre, r_ref, r_pend};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL ref_no_queue v%0d cycle %0d got=%b exp=%b", v, k, got, exp);
        end
        if (k == 1) wr_req = 1'b0;
        page_stop = (k == stop);
      end
      page_stop = 1'b0; page_mod = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access;
    int r0;
    do_reset(r0);
    rd_req = 1'b1; bur_len = 4'd8; cas_lat = 2'd3;
    @(negedge clk0);
    rd_req = 1'b0;
    repeat (T_RCD + 4) @(negedge clk0);
    checks++;
    if (d_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got=%b exp=1", d_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy, d_pend} !== 9'b0) begin
      errors++;
      $display("FAIL mid_async_reset got=%b exp=000000000",
               {d_act, d_rda, d_wra, d_pre, d_ref, d_rack, d_wack, d_busy, d_pend});
    end
    repeat (2) @(negedge clk0);
    reset_n = 1'b1; rd_req = 1'b1;
    @(negedge clk0);
    checks++;
    if ({d_act, d_rack, d_wack} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_grant got act/rd/wr=%b exp=110", {d_act, d_rack, d_wack});
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_access();
    test_round_robin();
    test_refresh_priority();
    test_ref_no_queue();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_scheduler.md
SDRAM_CMD_SCHEDULER -- requirements
Module: sdram_cmd_scheduler

Interface
REQ-001 Parameter: REF_INTERVAL, default 390, clk0 cycles between refresh requests.
REQ-002 Parameter: T_RCD, default 2, ACTIVE-to-command cycles (legal 1..15).
REQ-003 Parameter: T_RP, default 2, precharge-to-IDLE cycles (legal 1..15).
REQ-004 Parameter: T_RFC, default 7, refresh-to-IDLE cycles (legal 1..15).
REQ-005 clk0  in  1  sole clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rd_req  in  1  level read request; held until rd_ack.
REQ-008 wr_req  in  1  level write request; held until wr_ack.
REQ-009 page_mod  in  1  1 = page-mode access, 0 = fixed burst.
REQ-010 page_stop  in  1  terminates an open page-mode access.
REQ-011 bur_len  in  4  burst length: legal values 1, 2, 4, 8.
REQ-012 cas_lat  in  2  CAS latency: legal values 2, 3.
REQ-013 do_active  out  1  one-cycle ACTIVE strobe.
REQ-014 do_reada  out  1  one-cycle READ-with-autoprecharge strobe.
REQ-015 do_writea1  out  1  one-cycle WRITE-with-autoprecharge strobe (drives oe_generator).
REQ-016 do_preacharge  out  1  one-cycle explicit PRECHARGE strobe (page-mode only).
REQ-017 do_refresh  out  1  one-cycle AUTO-REFRESH strobe.
REQ-018 rd_ack / wr_ack  out  1 each  one-cycle grant pulses.
REQ-019 busy  out  1  high whenever FSM is not IDLE.
REQ-020 ref_pending  out  1  refresh owed, not yet issued.

Function
REQ-021 FSM states: IDLE, ACT, RCD, CMD, DATA, PRE, RP, REF, RFC; all outputs registered.
REQ-022 Refresh counter loads REF_INTERVAL-1, decrements every cycle, on 0 sets ref_pending and reloads; an expiry while pending leaves ref_pending=1 (no queuing).
REQ-023 IDLE priority: ref_pending > requests; between rd_req and wr_req, round-robin (last-granted loses ties; after reset, write wins the first tie).
REQ-024 Grant: IDLE->ACT; do_active=1 and matching rd_ack/wr_ack=1 in the ACT cycle; bur_len, cas_lat, page_mod, direction latched at the grant edge.
REQ-025 ACT->RCD for T_RCD-1 cycles (T_RCD=1 skips RCD) ->CMD; CMD asserts do_reada or do_writea1 for exactly one cycle.
REQ-026 Non-page DATA duration: bur_len cycles (write) or bur_len+cas_lat cycles (read); then RP directly (autoprecharge), no do_preacharge.
REQ-027 bur_len not in {1,2,4,8} is treated as 1; cas_lat not in {2,3} is treated as 3.
REQ-028 Page-mode DATA lasts until page_stop=1 is sampled (minimum 1 DATA cycle), then PRE: do_preacharge=1 one cycle, then RP.
REQ-029 RP lasts T_RP cycles, then IDLE; requests are sampled only in IDLE.
REQ-030 Refresh: IDLE & ref_pending -> REF (do_refresh=1 one cycle, ref_pending cleared same edge unless counter expires same edge, then stays 1) -> RFC for T_RFC-1 cycles -> IDLE.
REQ-031 At most one do_* strobe high in any cycle; ack only in ACT.
REQ-032 page_stop outside page-mode DATA is ignored; requests arriving mid-access wait.

Reset
REQ-033 reset_n=0 immediately forces IDLE, all do_*, acks, busy, ref_pending to 0, counter to REF_INTERVAL-1, round-robin pointer to "write next", regardless of state mid-access.
REQ-034 First refresh request after reset_n release occurs REF_INTERVAL cycles later.

Verification
REQ-035 Single write, bur_len=4, page_mod=0, defaults: wr_req at IDLE -> do_active+wr_ack cycle N, do_writea1 N+2, busy falls N+9.
REQ-036 Single read, bur_len=8, cas_lat=3: do_active N, do_reada N+2, DATA 11 cycles, IDLE at N+16; no do_preacharge.
REQ-037 rd_req and wr_req held together from reset: grants alternate wr, rd, wr, rd.
REQ-038 Page-mode write, page_stop pulsed 20 cycles after do_writea1 -> do_preacharge one cycle after sampling, IDLE T_RP cycles later.
REQ-039 REF_INTERVAL=20, wr_req pending at expiry in IDLE -> do_refresh first, ref_pending clears, do_active follows RFC completion.
REQ-040 reset_n low during DATA of an 8-beat read -> all outputs 0 asynchronously; after release, new rd_req gets do_active on first IDLE sample.
